// File: rtl/rv32_pkg.sv
// Shared rv32im core constants and the store-queue entry layout.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CSR_AW = 12;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] be;
    } sq_entry_t;

    // Pointer width for a power-of-two queue: index bits plus one wrap bit.
    function automatic int unsigned sq_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wrbk_sq_if.sv
// Data-memory store port: head-of-queue request towards memory, grant back.
interface wrbk_sq_if #(
    parameter int XLEN = 32
);
    logic              mem_req_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_data_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic              mem_gnt_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
        input  mem_gnt_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
        output mem_gnt_i
    );
endinterface

// File: rtl/wrbk_sq_fifo.sv
// Store-queue FIFO with wrap-bit pointers; exposes storage and valid mask for hazard compares.
module wrbk_sq_fifo #(
    parameter int unsigned WIDTH = 68,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries,
    output logic [DEPTH-1:0]             valid
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        do_push;
    logic                        do_pop;
    logic [AW-1:0]               offset;

    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign entries   = mem;

    // A slot is live when its distance from the read index is below the occupancy.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset   = AW'(i) - rd_ptr[AW-1:0];
            valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/wrbk_sq.sv
// Writeback stage: registered reg/CSR writes plus a store queue draining to data memory.
module wrbk_sq #(
    parameter int XLEN     = rv32_pkg::XLEN,
    parameter int REG_AW   = rv32_pkg::REG_AW,
    parameter int CSR_AW   = rv32_pkg::CSR_AW,
    parameter int SQ_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      state_wrbk_i,
    input  logic                      wrbk_reg_wr_en_i,
    input  logic [REG_AW-1:0]         wrbk_reg_addr_i,
    input  logic [XLEN-1:0]           wrbk_reg_data_i,
    input  logic                      wrbk_csr_wr_en_i,
    input  logic [CSR_AW-1:0]         wrbk_csr_addr_i,
    input  logic [XLEN-1:0]           wrbk_csr_data_i,
    input  logic                      wrbk_mem_wr_en_i,
    input  logic [XLEN-1:0]           wrbk_mem_addr_i,
    input  logic [XLEN-1:0]           wrbk_mem_data_i,
    input  logic [XLEN/8-1:0]         wrbk_mem_be_i,
    input  logic                      fence_i,
    input  logic [XLEN-1:0]           chk_addr_i,
    output logic                      wrbk_reg_wr_en_o,
    output logic [REG_AW-1:0]         wrbk_reg_addr_o,
    output logic [XLEN-1:0]           wrbk_reg_data_o,
    output logic                      wrbk_csr_wr_en_o,
    output logic [CSR_AW-1:0]         wrbk_csr_addr_o,
    output logic [XLEN-1:0]           wrbk_csr_data_o,
    wrbk_sq_if.master                 mem,
    output logic                      chk_hit_o,
    output logic [$clog2(SQ_DEPTH):0] sq_count_o,
    output logic                      sq_empty_o,
    output logic                      sq_full_o,
    output logic                      wrbk_ready_o
);
    import rv32_pkg::*;

    localparam int unsigned PW = sq_ptr_w(SQ_DEPTH);
    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned EW = 2 * XLEN + BW;

    logic                         acc;
    logic                         push;
    logic                         pop;
    logic [EW-1:0]                push_entry;
    logic [EW-1:0]                head_entry;
    logic [SQ_DEPTH-1:0][EW-1:0]  entries;
    logic [SQ_DEPTH-1:0]          valid;
    logic [PW-1:0]                count;

    // Ready never looks at mem_gnt_i: a full queue blocks the push even if it pops this cycle.
    assign wrbk_ready_o = state_wrbk_i && !(wrbk_mem_wr_en_i && sq_full_o) && !(fence_i && !sq_empty_o);
    assign acc          = state_wrbk_i && wrbk_ready_o;
    assign push         = acc && wrbk_mem_wr_en_i;
    assign pop          = mem.mem_req_o && mem.mem_gnt_i;
    assign push_entry   = {wrbk_mem_addr_i, wrbk_mem_data_i, wrbk_mem_be_i};

    wrbk_sq_fifo #(
        .WIDTH (EW),
        .DEPTH (SQ_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count),
        .full      (sq_full_o),
        .empty     (sq_empty_o),
        .entries   (entries),
        .valid     (valid)
    );

    assign sq_count_o     = count;
    assign mem.mem_req_o  = !sq_empty_o;
    assign mem.mem_addr_o = head_entry[EW-1 -: XLEN];
    assign mem.mem_data_o = head_entry[BW +: XLEN];
    assign mem.mem_be_o   = head_entry[BW-1:0];

    always_comb begin
        chk_hit_o = 1'b0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (valid[i] && (entries[i][EW-1 -: XLEN-2] == chk_addr_i[XLEN-1:2])) chk_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrbk_reg_wr_en_o <= 1'b0;
            wrbk_reg_addr_o  <= '0;
            wrbk_reg_data_o  <= '0;
            wrbk_csr_wr_en_o <= 1'b0;
            wrbk_csr_addr_o  <= '0;
            wrbk_csr_data_o  <= '0;
        end else if (acc) begin
            wrbk_reg_wr_en_o <= wrbk_reg_wr_en_i;
            wrbk_reg_addr_o  <= wrbk_reg_addr_i;
            wrbk_reg_data_o  <= wrbk_reg_data_i;
            wrbk_csr_wr_en_o <= wrbk_csr_wr_en_i;
            wrbk_csr_addr_o  <= wrbk_csr_addr_i;
            wrbk_csr_data_o  <= wrbk_csr_data_i;
        end else begin
            wrbk_reg_wr_en_o <= 1'b0;
            wrbk_csr_wr_en_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wrbk_sq.sv
// Self-checking bench for wrbk_sq: directed scenarios plus randomized stress against a queue model.
module tb_wrbk_sq;
    import rv32_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        state_wrbk, reg_en, csr_en, mem_en, fence;
    logic [4:0]  reg_addr;
    logic [11:0] csr_addr;
    logic [31:0] reg_data, csr_data, mem_addr, mem_data, chk_addr;
    logic [3:0]  mem_be;

    logic        reg_en_o, csr_en_o, chk_hit, sq_empty, sq_full, ready;
    logic [4:0]  reg_addr_o;
    logic [11:0] csr_addr_o;
    logic [31:0] reg_data_o, csr_data_o;
    logic [2:0]  sq_count;

    wrbk_sq_if #(.XLEN(32)) sq_if ();

    always #5 clk = ~clk;

    wrbk_sq #(.XLEN(32), .REG_AW(5), .CSR_AW(12), .SQ_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_n), .state_wrbk_i(state_wrbk),
        .wrbk_reg_wr_en_i(reg_en), .wrbk_reg_addr_i(reg_addr), .wrbk_reg_data_i(reg_data),
        .wrbk_csr_wr_en_i(csr_en), .wrbk_csr_addr_i(csr_addr), .wrbk_csr_data_i(csr_data),
        .wrbk_mem_wr_en_i(mem_en), .wrbk_mem_addr_i(mem_addr), .wrbk_mem_data_i(mem_data),
        .wrbk_mem_be_i(mem_be), .fence_i(fence), .chk_addr_i(chk_addr),
        .wrbk_reg_wr_en_o(reg_en_o), .wrbk_reg_addr_o(reg_addr_o), .wrbk_reg_data_o(reg_data_o),
        .wrbk_csr_wr_en_o(csr_en_o), .wrbk_csr_addr_o(csr_addr_o), .wrbk_csr_data_o(csr_data_o),
        .mem(sq_if.master), .chk_hit_o(chk_hit), .sq_count_o(sq_count),
        .sq_empty_o(sq_empty), .sq_full_o(sq_full), .wrbk_ready_o(ready)
    );

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;

    sq_entry_t   mq[$];
    logic        exp_reg_en, exp_csr_en;
    logic [4:0]  exp_reg_addr;
    logic [11:0] exp_csr_addr;
    logic [31:0] exp_reg_data, exp_csr_data;

    function automatic bit model_hit(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].addr[31:2] == a[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock, applying the writeback/queue rules to the reference model.
    task automatic tick();
        bit acc, pop;
        sq_entry_t e;
        acc = state_wrbk && !(mem_en && mq.size() == DEPTH) && !(fence && mq.size() != 0);
        pop = (mq.size() != 0) && sq_if.mem_gnt_i;
        e.addr = mem_addr; e.data = mem_data; e.be = mem_be;
        @(posedge clk);
        if (pop) begin void'(mq.pop_front()); pops++; end
        if (acc && mem_en) mq.push_back(e);
        if (acc) begin
            exp_reg_en = reg_en; exp_reg_addr = reg_addr; exp_reg_data = reg_data;
            exp_csr_en = csr_en; exp_csr_addr = csr_addr; exp_csr_data = csr_data;
        end else begin
            exp_reg_en = 1'b0; exp_csr_en = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        state_wrbk = 0; reg_en = 0; csr_en = 0; mem_en = 0; fence = 0;
        sq_if.mem_gnt_i = 0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (sq_if.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", sq_if.mem_req_o); end
        vectors++; if (sq_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", sq_count); end
        vectors++; if (sq_empty !== 1'b1 || sq_full !== 1'b0) begin miscompares++; $display("FAIL reset_status got=e%b f%b exp=e1 f0", sq_empty, sq_full); end
        vectors++; if (reg_en_o !== 1'b0 || reg_addr_o !== 5'd0 || reg_data_o !== 32'd0) begin miscompares++; $display("FAIL reset_reg got=%b %0d %h exp=0 0 0", reg_en_o, reg_addr_o, reg_data_o); end
        vectors++; if (csr_en_o !== 1'b0 || csr_addr_o !== 12'd0 || csr_data_o !== 32'd0) begin miscompares++; $display("FAIL reset_csr got=%b %h %h exp=0 0 0", csr_en_o, csr_addr_o, csr_data_o); end
        vectors++; if (chk_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got=%b exp=0", chk_hit); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_reg_en = 0; exp_reg_addr = 0; exp_reg_data = 0;
        exp_csr_en = 0; exp_csr_addr = 0; exp_csr_data = 0;
        mq.delete();
    endtask

    task automatic test_reg_write();
        state_wrbk = 1; reg_en = 1; reg_addr = 5'd5; reg_data = 32'hDEADBEEF;
        #1;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reg_ready got=%b exp=1", ready); end
        tick();
        vectors++; if (reg_en_o !== 1'b1 || reg_addr_o !== 5'd5 || reg_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL reg_write got=%b %0d %h exp=1 5 deadbeef", reg_en_o, reg_addr_o, reg_data_o); end
        idle_inputs();
        tick();
        vectors++; if (reg_en_o !== 1'b0 || reg_addr_o !== 5'd5 || reg_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL reg_hold got=%b %0d %h exp=0 5 deadbeef", reg_en_o, reg_addr_o, reg_data_o); end
        state_wrbk = 1; reg_en = 1; reg_addr = 5'd0; reg_data = 32'h00001234;
        tick();
        vectors++; if (reg_en_o !== 1'b1 || reg_addr_o !== 5'd0 || reg_data_o !== 32'h00001234) begin miscompares++; $display("FAIL reg_x0 got=%b %0d %h exp=1 0 1234", reg_en_o, reg_addr_o, reg_data_o); end
        idle_inputs();
    endtask

    task automatic test_csr_write();
        state_wrbk = 1; csr_en = 1; csr_addr = 12'h305; csr_data = 32'hCAFE0123;
        tick();
        vectors++; if (csr_en_o !== 1'b1 || csr_addr_o !== 12'h305 || csr_data_o !== 32'hCAFE0123) begin miscompares++; $display("FAIL csr_write got=%b %h %h exp=1 305 cafe0123", csr_en_o, csr_addr_o, csr_data_o); end
        vectors++; if (reg_en_o !== 1'b0) begin miscompares++; $display("FAIL csr_no_reg got=%b exp=0", reg_en_o); end
        idle_inputs();
        tick();
        vectors++; if (csr_en_o !== 1'b0 || csr_addr_o !== 12'h305) begin miscompares++; $display("FAIL csr_hold got=%b %h exp=0 305", csr_en_o, csr_addr_o); end
    endtask

    task automatic test_full_backpressure();
        sq_if.mem_gnt_i = 0; state_wrbk = 1; mem_en = 1; mem_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            mem_addr = 32'h100 + 32'(4 * k); mem_data = 32'hA000 + 32'(k);
            #1;
            vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL full_ready%0d got=%b exp=1", k, ready); end
            tick();
        end
        vectors++; if (sq_full !== 1'b1 || sq_count !== 3'd4) begin miscompares++; $display("FAIL full_status got=f%b c%0d exp=f1 c4", sq_full, sq_count); end
        mem_addr = 32'h110; mem_data = 32'hA004;
        #1;
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL full_block got=%b exp=0", ready); end
        vectors++; if (sq_if.mem_req_o !== 1'b1 || sq_if.mem_addr_o !== 32'h100) begin miscompares++; $display("FAIL full_head got=%b %h exp=1 100", sq_if.mem_req_o, sq_if.mem_addr_o); end
        sq_if.mem_gnt_i = 1;
        #1;
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL full_gnt_block got=%b exp=0", ready); end
        tick();
        sq_if.mem_gnt_i = 0;
        #1;
        vectors++; if (ready !== 1'b1 || sq_count !== 3'd3 || sq_if.mem_addr_o !== 32'h104) begin miscompares++; $display("FAIL full_after_pop got=r%b c%0d %h exp=r1 c3 104", ready, sq_count, sq_if.mem_addr_o); end
        tick();
        idle_inputs();
        sq_if.mem_gnt_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++; if (sq_if.mem_req_o !== 1'b1 || sq_if.mem_addr_o !== 32'h104 + 32'(4 * k) || sq_if.mem_data_o !== 32'hA001 + 32'(k)) begin miscompares++; $display("FAIL drain%0d got=%b %h %h exp=1 %h %h", k, sq_if.mem_req_o, sq_if.mem_addr_o, sq_if.mem_data_o, 32'h104 + 32'(4 * k), 32'hA001 + 32'(k)); end
            tick();
        end
        vectors++; if (sq_empty !== 1'b1 || sq_if.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL drain_empty got=e%b r%b exp=e1 r0", sq_empty, sq_if.mem_req_o); end
        idle_inputs();
    endtask

    task automatic test_hazard();
        state_wrbk = 1; mem_en = 1; mem_addr = 32'h1004; mem_data = 32'h55; mem_be = 4'b0001; chk_addr = 32'h1004;
        #1;
        vectors++; if (chk_hit !== 1'b0) begin miscompares++; $display("FAIL hz_same_cycle got=%b exp=0", chk_hit); end
        tick();
        idle_inputs();
        chk_addr = 32'h1007; #1;
        vectors++; if (chk_hit !== 1'b1) begin miscompares++; $display("FAIL hz_1007 got=%b exp=1", chk_hit); end
        chk_addr = 32'h1008; #1;
        vectors++; if (chk_hit !== 1'b0) begin miscompares++; $display("FAIL hz_1008 got=%b exp=0", chk_hit); end
        chk_addr = 32'h1000; #1;
        vectors++; if (chk_hit !== 1'b0) begin miscompares++; $display("FAIL hz_1000 got=%b exp=0", chk_hit); end
        vectors++; if (sq_if.mem_be_o !== 4'b0001 || sq_if.mem_data_o !== 32'h55) begin miscompares++; $display("FAIL hz_head got=%b %h exp=0001 55", sq_if.mem_be_o, sq_if.mem_data_o); end
        chk_addr = 32'h1007; sq_if.mem_gnt_i = 1;
        tick();
        sq_if.mem_gnt_i = 0; #1;
        vectors++; if (chk_hit !== 1'b0 || sq_empty !== 1'b1) begin miscompares++; $display("FAIL hz_after_gnt got=h%b e%b exp=h0 e1", chk_hit, sq_empty); end
    endtask

    task automatic test_fence();
        int c;
        state_wrbk = 1; mem_en = 1; mem_be = 4'hF;
        mem_addr = 32'h300; mem_data = 32'h1; tick();
        mem_addr = 32'h304; mem_data = 32'h2; tick();
        mem_en = 0; fence = 1; reg_en = 1; reg_addr = 5'd7; reg_data = 32'h77;
        c = 0;
        while (c < 20) begin
            sq_if.mem_gnt_i = c[0];
            #1;
            vectors++; if (ready !== (mq.size() == 0) || sq_empty !== (mq.size() == 0)) begin miscompares++; $display("FAIL fence_c%0d got=r%b e%b exp=%b", c, ready, sq_empty, mq.size() == 0); end
            if (ready === 1'b1) break;
            tick();
            c++;
        end
        vectors++; if (c != 4) begin miscompares++; $display("FAIL fence_release got=cycle%0d exp=cycle4", c); end
        tick();
        vectors++; if (reg_en_o !== 1'b1 || reg_addr_o !== 5'd7) begin miscompares++; $display("FAIL fence_accept got=%b %0d exp=1 7", reg_en_o, reg_addr_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        state_wrbk = 1; mem_en = 1; mem_be = 4'hF; sq_if.mem_gnt_i = 0;
        for (int k = 0; k < 3; k++) begin
            mem_addr = 32'h400 + 32'(4 * k); mem_data = 32'hB0 + 32'(k); tick();
        end
        idle_inputs();
        chk_addr = 32'h404; #1;
        vectors++; if (sq_count !== 3'd3 || sq_if.mem_req_o !== 1'b1 || chk_hit !== 1'b1) begin miscompares++; $display("FAIL rmo_pre got=c%0d r%b h%b exp=c3 r1 h1", sq_count, sq_if.mem_req_o, chk_hit); end
        rst_n = 1'b0; #1;
        vectors++; if (sq_if.mem_req_o !== 1'b0 || sq_count !== 3'd0 || sq_empty !== 1'b1 || chk_hit !== 1'b0) begin miscompares++; $display("FAIL rmo_async got=r%b c%0d e%b h%b exp=r0 c0 e1 h0", sq_if.mem_req_o, sq_count, sq_empty, chk_hit); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete();
        exp_reg_en = 0; exp_reg_addr = 0; exp_reg_data = 0;
        exp_csr_en = 0; exp_csr_addr = 0; exp_csr_data = 0;
        sq_if.mem_gnt_i = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (sq_if.mem_req_o !== 1'b0 || sq_count !== 3'd0) begin miscompares++; $display("FAIL rmo_stale%0d got=r%b c%0d exp=r0 c0", k, sq_if.mem_req_o, sq_count); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random_stress();
        int start_pops;
        start_pops = pops;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            state_wrbk = ($urandom_range(0, 3) != 0);
            reg_en = $urandom_range(0, 1); reg_addr = 5'($urandom); reg_data = $urandom;
            csr_en = $urandom_range(0, 1); csr_addr = 12'($urandom); csr_data = $urandom;
            mem_en = ($urandom_range(0, 9) < 6);
            mem_addr = 32'h2000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            mem_data = $urandom; mem_be = 4'($urandom);
            fence = ($urandom_range(0, 19) == 0);
            chk_addr = 32'h2000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            sq_if.mem_gnt_i = $urandom_range(0, 1);
            #1;
            vectors++; if (ready !== (state_wrbk && !(mem_en && mq.size() == DEPTH) && !(fence && mq.size() != 0))) begin miscompares++; $display("FAIL rnd_ready cyc%0d got=%b size=%0d", cyc, ready, mq.size()); end
            vectors++; if (sq_count !== 3'(mq.size()) || sq_empty !== (mq.size() == 0) || sq_full !== (mq.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_status cyc%0d got=c%0d e%b f%b exp=c%0d", cyc, sq_count, sq_empty, sq_full, mq.size()); end
            vectors++; if (sq_if.mem_req_o !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_req cyc%0d got=%b exp=%b", cyc, sq_if.mem_req_o, mq.size() != 0); end
            if (mq.size() != 0) begin
                vectors++; if (sq_if.mem_addr_o !== mq[0].addr || sq_if.mem_data_o !== mq[0].data || sq_if.mem_be_o !== mq[0].be) begin miscompares++; $display("FAIL rnd_head cyc%0d got=%h %h %b exp=%h %h %b", cyc, sq_if.mem_addr_o, sq_if.mem_data_o, sq_if.mem_be_o, mq[0].addr, mq[0].data, mq[0].be); end
            end
            vectors++; if (chk_hit !== model_hit(chk_addr)) begin miscompares++; $display("FAIL rnd_hit cyc%0d got=%b exp=%b", cyc, chk_hit, model_hit(chk_addr)); end
            tick();
            vectors++; if (reg_en_o !== exp_reg_en || reg_addr_o !== exp_reg_addr || reg_data_o !== exp_reg_data) begin miscompares++; $display("FAIL rnd_reg cyc%0d got=%b %0d %h exp=%b %0d %h", cyc, reg_en_o, reg_addr_o, reg_data_o, exp_reg_en, exp_reg_addr, exp_reg_data); end
            vectors++; if (csr_en_o !== exp_csr_en || csr_addr_o !== exp_csr_addr || csr_data_o !== exp_csr_data) begin miscompares++; $display("FAIL rnd_csr cyc%0d got=%b %h %h exp=%b %h %h", cyc, csr_en_o, csr_addr_o, csr_data_o, exp_csr_en, exp_csr_addr, exp_csr_data); end
        end
        vectors++; if (pops - start_pops < 100 * 2 * DEPTH) begin miscompares++; $display("FAIL rnd_wraps got=%0d pops exp>=%0d", pops - start_pops, 100 * 2 * DEPTH); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reg_addr = 0; reg_data = 0; csr_addr = 0; csr_data = 0;
        mem_addr = 0; mem_data = 0; mem_be = 0; chk_addr = 0;
        test_reset();
        test_reg_write();
        test_csr_write();
        test_full_backpressure();
        test_hazard();
        test_fence();
        test_reset_mid_op();
        test_random_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wrbk_sq.md
# wrbk_sq

Parametrised writeback stage with a store queue for the rv32im core. It registers register-file and CSR writes, and buffers memory stores in a FIFO of configurable depth. The FIFO drains to the data-memory port through a request/grant handshake, so a slow memory no longer stalls every instruction. It sits between the execute/memory stage and the register file, CSR file and data-memory interface. It is controlled by the core state machine through `state_wrbk_i` / `wrbk_ready_o`.

## Interface
- `XLEN`, 32: data and address width.
- `REG_AW`, 5: register-file address width.
- `CSR_AW`, 12: CSR address width.
- `SQ_DEPTH`, 4: store-queue entries; power of two, ≥ 2.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `state_wrbk_i` in 1: core is in writeback state; the instruction is presented this cycle.
- `wrbk_reg_wr_en_i` / `wrbk_reg_addr_i` / `wrbk_reg_data_i` in 1 / REG_AW / XLEN: register write request.
- `wrbk_csr_wr_en_i` / `wrbk_csr_addr_i` / `wrbk_csr_data_i` in 1 / CSR_AW / XLEN: CSR write request.
- `wrbk_mem_wr_en_i` / `wrbk_mem_addr_i` / `wrbk_mem_data_i` / `wrbk_mem_be_i` in 1 / XLEN / XLEN / XLEN/8: store request with byte enables.
- `fence_i` in 1: stall writeback until the queue is empty.
- `chk_addr_i` in XLEN: load address for the store-hazard check.
- `mem_gnt_i` in 1: memory accepts the head store.
- `wrbk_reg_wr_en_o` / `wrbk_reg_addr_o` / `wrbk_reg_data_o` out 1 / REG_AW / XLEN: registered register write.
- `wrbk_csr_wr_en_o` / `wrbk_csr_addr_o` / `wrbk_csr_data_o` out 1 / CSR_AW / XLEN: registered CSR write.
- `mem_req_o` / `mem_addr_o` / `mem_data_o` / `mem_be_o` out 1 / XLEN / XLEN / XLEN/8: head-of-queue store.
- `chk_hit_o` out 1: a queued store overlaps the word at `chk_addr_i`.
- `sq_count_o` out $clog2(SQ_DEPTH)+1: occupancy.
- `sq_empty_o`, `sq_full_o` out 1: queue status.
- `wrbk_ready_o` out 1: instruction accepted this cycle.

## Operation
- Accept condition: `acc = state_wrbk_i && wrbk_ready_o`.
- `wrbk_ready_o = state_wrbk_i && !(wrbk_mem_wr_en_i && sq_full_o) && !(fence_i && !sq_empty_o)`.
- Register path:
  - On `acc`, register enable, address and data.
  - Otherwise the enable is forced to 0 next cycle; address and data hold.
  - A write to x0 is passed through; the register file ignores it.
- CSR path: same as the register path.
- Push:
  - Condition: `acc && wrbk_mem_wr_en_i`.
  - Writes {addr, data, be} at the write pointer.
  - A full queue blocks the push even if a pop occurs the same cycle, so no same-cycle bypass.
- Pop:
  - `mem_req_o = !sq_empty_o`.
  - The head fields drive `mem_*_o` directly from storage.
  - Pop condition: `mem_req_o && mem_gnt_i`.
  - `mem_gnt_i` while empty is ignored.
- Simultaneous push and pop on a non-full, non-empty queue: count unchanged, both pointers advance.
- Push into an empty queue: `mem_req_o` rises the next cycle.
- Pointers: $clog2(SQ_DEPTH)+1 bits with a wrap bit.
  - Full when the index bits are equal and the wrap bits differ.
  - Empty when the pointers are fully equal.
  - Pointers wrap naturally modulo 2·SQ_DEPTH.
- Hazard check:
  - `chk_hit_o` is 1 if any valid entry has `addr[XLEN-1:2] == chk_addr_i[XLEN-1:2]`.
  - Byte enables are ignored, which is conservative.
  - Combinational over the valid entries only.
  - An entry pushed this cycle is not yet visible.
- Fence: while `fence_i` is set and the queue is not empty, `wrbk_ready_o` is 0 and the queue keeps draining.

## Timing
- Reset (`rst_i` low, asynchronous):
  - All pointers and enables clear to 0.
  - `wrbk_reg_wr_en_o`, `wrbk_csr_wr_en_o`, `mem_req_o`, `chk_hit_o` = 0; `sq_count_o` = 0; `sq_empty_o` = 1; `sq_full_o` = 0.
  - Registered address/data outputs reset to 0.
  - Queue entries are discarded mid-operation; storage contents are don't-care.
- Reset release: first accept possible on the first rising edge after deassertion.
- Reg/CSR write: 1-cycle latency from the accepting edge.
- Store: earliest `mem_req_o` is 1 cycle after the push; minimum 1 cycle per store under continuous `mem_gnt_i`.
- `wrbk_ready_o`, `mem_*_o`, `chk_hit_o`: combinational from state and inputs, with no path from `mem_gnt_i` to `wrbk_ready_o`.
- Queue status outputs (`sq_count_o`, `sq_empty_o`, `sq_full_o`): registered.

## Structure
- Shared package `rv32_pkg`: `XLEN`, `REG_AW`, `CSR_AW` constants and the store-entry typedef {addr, data, be}.
- Sub-module `wrbk_sq_fifo`, parametrised by width and depth:
  - Provides push/pop, count, full/empty.
  - Exposes the entry array and a valid vector for the hazard compare.
- Top level holds the reg/CSR registers, the ready logic and the hazard comparator.

## Test plan
- Reset mid-operation:
  - Stimulus: fill 3 stores, then drop `rst_i` low while `mem_gnt_i` = 0.
  - Response: `mem_req_o` drops immediately and `sq_count_o` = 0; after release no stale store is issued.
- Register write:
  - Stimulus: register write x5 = 0xDEADBEEF with `state_wrbk_i` = 1.
  - Response: next cycle `wrbk_reg_wr_en_o` = 1, addr 5, data 0xDEADBEEF; the cycle after, enable = 0.
- Full queue backpressure:
  - Stimulus: `SQ_DEPTH` = 4 and `mem_gnt_i` = 0; 5 consecutive stores.
  - Response: `sq_full_o` = 1 after 4; `wrbk_ready_o` = 0 on the 5th.
  - Then a single `mem_gnt_i`: the head (first address) pops, and the 5th is accepted the following cycle.
- Hazard check:
  - Stimulus: queue a store to 0x1004 with be = 0001; set `chk_addr_i` = 0x1007, then 0x1008.
  - Response: `chk_hit_o` = 1, then 0; after the store is granted, 0x1007 → 0.
- Fence:
  - Stimulus: 2 stores queued, `fence_i` = 1, `mem_gnt_i` pulsed every other cycle.
  - Response: `wrbk_ready_o` stays 0 until `sq_empty_o` = 1, then goes to 1 in the same cycle.
- Random stress:
  - Stimulus: random push/grant for 10k cycles, with the pointers wrapping more than 100 times.
  - Response: a scoreboard confirms in-order, lossless stores with correct `sq_count_o`.
